iter_shift_unit: RTL and testbench
==================================

# iter_shift_unit

Parametrised multi-cycle shift/rotate unit for the CPU datapath. It replaces the single-cycle SHR path through the ALU and adds arithmetic right shift, left shift and both rotates. It shifts by a configurable number of bits per clock and reports completion through a start/busy/done handshake, so the control sequencer can hold its T-state until the result is ready. The result is then driven onto the bus through the Z register path.

## Interface
- WIDTH, 32: operand and result width in bits.
- SHAMT_W, 5: shift-amount width; must equal clog2(WIDTH).
- STEP, 1: bits shifted per SHIFT cycle; a power of two, 1 ≤ STEP ≤ WIDTH.

- clk  input  1  system clock; all state changes on its rising edge.
- clr  input  1  reset; asynchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- mode  input  3  operation: 000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL; 101–111 pass the operand through unchanged.
- operand  input  WIDTH  value to shift; sampled with start.
- shamt  input  SHAMT_W  shift count, 0..WIDTH-1; sampled with start.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  high for exactly one cycle when result becomes valid.
- result  output  WIDTH  shifted value; held from done until the next accepted start.

## Operation
- Reset (clr=1, any time, including mid-operation):
  - state=IDLE.
  - busy=0, done=0, result=0.
  - Internal operand, mode and remaining-count registers cleared.
- States are IDLE, SHIFT and DONE.
- IDLE:
  - start=1 latches operand into the working register, plus mode and remaining=shamt.
  - With an illegal mode or shamt=0, the state goes to DONE; otherwise to SHIFT.
- SHIFT:
  - Each edge applies k = min(STEP, remaining) bit positions and sets remaining -= k.
  - When remaining reaches 0 on that edge, the state goes to DONE.
- DONE:
  - done=1 and result = working register.
  - The next edge returns to IDLE unconditionally.
- Per-step rules (k bits):
  - SHR fills 0 from the MSB side.
  - SHRA replicates the original bit WIDTH-1.
  - SHL fills 0 from the LSB side.
  - ROR moves the low k bits to the top; ROL moves the high k bits to the bottom.
- Final result equals the single-shot operation by shamt (rotates modulo WIDTH).
- start while busy=1 (SHIFT or DONE) is ignored and not queued.
- Operand, mode and shamt inputs may change freely after the accepting edge without affecting the operation.
- result updates only on the edge entering DONE and then holds through IDLE until the next accepted start; it never shows intermediate values.

## Timing
- Let n = ceil(shamt/STEP); n = 0 for shamt=0 or an illegal mode.
- Accepting edge E0: busy rises after E0.
- SHIFT occupies edges E1..En; done=1 and result valid in the cycle after edge En, or after E0 when n=0.
- The edge after that returns to IDLE with busy=0 and done=0.
- A new start is accepted no earlier than that IDLE cycle.
- Start-to-done latency is n+1 edges (E0..En).
- Back-to-back throughput: one operation per n+2 cycles.
- clr asserted between edges clears outputs immediately, with no clock needed.
- start=1 on the first edge after clr deasserts is accepted normally.

## Test plan
- WIDTH=32, STEP=1, SHR: operand 0x00000012, shamt 2, start one cycle → busy 2 SHIFT cycles, done one cycle later with result 0x00000004; result still 0x00000004 ten cycles later.
- STEP=1, SHRA: operand 0x80000000, shamt 4 → result 0xF8000000 after 4 SHIFT cycles. SHR with the same inputs → 0x08000000.
- STEP=1, ROL: operand 0x80000001, shamt 1 → result 0x00000003. ROR: operand 0x00000003, shamt 1 → 0x80000001.
- STEP=4, SHL: operand 0x00000001, shamt 31 → exactly 8 SHIFT cycles (7×4 + 3), result 0x80000000.
- Boundary cases:
  - shamt=0 with operand 0xDEADBEEF → done the cycle after start, result 0xDEADBEEF.
  - mode 111 → same behaviour.
  - A second start during SHIFT with operand 0xFFFFFFFF is ignored and the first result is unaffected.
- Reset mid-op: SHR 0x000000FF by 20, clr pulsed after 5 SHIFT cycles → busy, done and result 0 immediately with no clock edge. A subsequent SHR 0x0000000A by 1 → 0x00000005.

Source files
------------

// File: rtl/iter_shift_unit.sv
// Multi-cycle shift/rotate unit: shifts up to STEP bit positions per clock and
// reports completion with a start/busy/done handshake.
module iter_shift_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 1
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic [2:0]         mode,
    input  logic [WIDTH-1:0]   operand,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam logic [SHAMT_W:0] STEP_C  = (SHAMT_W + 1)'(STEP);
    localparam logic [SHAMT_W:0] WIDTH_C = (SHAMT_W + 1)'(WIDTH);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [2:0]         mode_q, mode_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [SHAMT_W:0]   k_s;
    logic [WIDTH-1:0]   shifted_s;

    // One partial step of k positions; k never exceeds WIDTH, so the rotate
    // complement is always a legal shift amount.
    function automatic logic [WIDTH-1:0] step_shift(
        input logic [WIDTH-1:0] v,
        input logic [2:0]       m,
        input logic [SHAMT_W:0] k
    );
        logic [SHAMT_W:0] kc;
        kc = WIDTH_C - k;
        case (m)
            3'b000:  step_shift = v >> k;
            3'b001:  step_shift = $unsigned($signed(v) >>> k);
            3'b010:  step_shift = v << k;
            3'b011:  step_shift = (v >> k) | (v << kc);
            3'b100:  step_shift = (v << k) | (v >> kc);
            default: step_shift = v;
        endcase
    endfunction

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        mode_d    = mode_q;
        rem_d     = rem_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        result_d  = result_q;
        k_s       = ({1'b0, rem_q} < STEP_C) ? {1'b0, rem_q} : STEP_C;
        shifted_s = step_shift(work_q, mode_q, k_s);
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    work_d = operand;
                    mode_d = mode;
                    rem_d  = shamt;
                    busy_d = 1'b1;
                    if ((mode > 3'd4) || (shamt == {SHAMT_W{1'b0}})) begin
                        state_d  = ST_DONE;
                        done_d   = 1'b1;
                        result_d = operand;
                    end else begin
                        state_d  = ST_SHIFT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                work_d = shifted_s;
                rem_d  = rem_q - k_s[SHAMT_W-1:0];
                busy_d = 1'b1;
                if ({1'b0, rem_q} == k_s) begin
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                    result_d = shifted_s;
                end else begin
                    state_d  = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= ST_IDLE;
            work_q   <= {WIDTH{1'b0}};
            mode_q   <= 3'b000;
            rem_q    <= {SHAMT_W{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= {WIDTH{1'b0}};
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            mode_q   <= mode_d;
            rem_q    <= rem_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_iter_shift_unit.sv
// Bench for iter_shift_unit: STEP=1 and STEP=4 instances share stimulus and are
// checked every cycle against a transaction-level model, plus literal checks.
module tb_iter_shift_unit;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [2:0]  mode;
    logic [31:0] operand;
    logic [4:0]  shamt;
    logic        busy1, done1, busy4, done4;
    logic [31:0] res1, res4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    iter_shift_unit #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) dut1 (
        .clk(clk), .clr(clr), .start(start), .mode(mode), .operand(operand),
        .shamt(shamt), .busy(busy1), .done(done1), .result(res1)
    );

    iter_shift_unit #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) dut4 (
        .clk(clk), .clr(clr), .start(start), .mode(mode), .operand(operand),
        .shamt(shamt), .busy(busy4), .done(done4), .result(res4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-operation reference: one shot by sh positions.
    function automatic logic [31:0] ref_op(input logic [2:0] m, input logic [31:0] v, input int sh);
        case (m)
            3'd0:    return v >> sh;
            3'd1:    return $unsigned($signed(v) >>> sh);
            3'd2:    return v << sh;
            3'd3:    return (sh == 0) ? v : ((v >> sh) | (v << (32 - sh)));
            3'd4:    return (sh == 0) ? v : ((v << sh) | (v >> (32 - sh)));
            default: return v;
        endcase
    endfunction

    // Model: per instance, cycles left until idle and the result to show.
    int          steps [2] = '{1, 4};
    int          m_cnt [2];
    logic [31:0] m_res [2];
    logic [31:0] m_pend[2];

    always @(posedge clk or posedge clr) begin : model
        int          nc;
        int          n;
        logic [31:0] np;
        if (clr) begin
            for (int i = 0; i < 2; i++) begin
                m_cnt[i]  <= 0;
                m_res[i]  <= 32'h0;
                m_pend[i] <= 32'h0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                nc = m_cnt[i];
                np = m_pend[i];
                if (nc == 0) begin
                    if (start) begin
                        n  = (mode > 3'd4 || shamt == 5'd0) ? 0 : (int'(shamt) + steps[i] - 1) / steps[i];
                        nc = n + 1;
                        np = ref_op(mode, operand, int'(shamt));
                    end
                end else begin
                    nc = nc - 1;
                end
                m_cnt[i]  <= nc;
                m_pend[i] <= np;
                if (nc == 1) m_res[i] <= np;
            end
        end
    end

    // Cycle-by-cycle comparison on the falling edge.
    always @(negedge clk) begin
        check("busy s1",   {31'b0, busy1}, {31'b0, m_cnt[0] != 0});
        check("done s1",   {31'b0, done1}, {31'b0, m_cnt[0] == 1});
        check("result s1", res1, m_res[0]);
        check("busy s4",   {31'b0, busy4}, {31'b0, m_cnt[1] != 0});
        check("done s4",   {31'b0, done4}, {31'b0, m_cnt[1] == 1});
        check("result s4", res4, m_res[1]);
    end

    task automatic wait_idle(output int c1, output int c4);
        bit ok;
        ok = 1'b0;
        c1 = 0;
        c4 = 0;
        for (int k = 0; k < 60; k++) begin
            if (busy1) c1++;
            if (busy4) c4++;
            if (!busy1 && !busy4) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("idle timeout", {31'b0, ok}, 32'd1);
    endtask

    task automatic run_op(input logic [2:0] m, input logic [31:0] v, input logic [4:0] s,
                          output int c1, output int c4);
        @(negedge clk);
        start = 1'b1; mode = m; operand = v; shamt = s;
        @(negedge clk);
        start = 1'b0; mode = 3'($urandom); operand = $urandom; shamt = 5'($urandom);
        wait_idle(c1, c4);
    endtask

    int c1, c4;

    initial begin
        clr = 1'b1; start = 1'b0; mode = 3'd0; operand = 32'h0; shamt = 5'd0;
        #3;
        check("reset busy",   {30'b0, busy1, busy4}, 32'd0);
        check("reset done",   {30'b0, done1, done4}, 32'd0);
        check("reset result", res1 | res4, 32'h0);
        @(negedge clk);
        clr = 1'b0;

        run_op(3'd0, 32'h0000_0012, 5'd2, c1, c4);
        check("shr res", res1, 32'h0000_0004);
        check("shr busy cycles", c1, 32'd3);
        repeat (10) @(negedge clk);
        check("shr hold", res1, 32'h0000_0004);

        run_op(3'd1, 32'h8000_0000, 5'd4, c1, c4);
        check("shra res", res1, 32'hF800_0000);
        check("shra busy cycles", c1, 32'd5);
        run_op(3'd0, 32'h8000_0000, 5'd4, c1, c4);
        check("shr msb res", res4, 32'h0800_0000);
        run_op(3'd4, 32'h8000_0001, 5'd1, c1, c4);
        check("rol res", res1, 32'h0000_0003);
        run_op(3'd3, 32'h0000_0003, 5'd1, c1, c4);
        check("ror res", res4, 32'h8000_0001);
        run_op(3'd2, 32'h0000_0001, 5'd31, c1, c4);
        check("shl step4 res", res4, 32'h8000_0000);
        check("shl step4 cycles", c4, 32'd9);
        run_op(3'd0, 32'hDEAD_BEEF, 5'd0, c1, c4);
        check("shamt0 res", res1, 32'hDEAD_BEEF);
        check("shamt0 cycles", c1, 32'd1);
        run_op(3'd7, 32'hDEAD_BEEF, 5'd5, c1, c4);
        check("mode7 res", res4, 32'hDEAD_BEEF);
        check("mode7 cycles", c4, 32'd1);

        // Second start while both instances are still busy must be dropped.
        @(negedge clk);
        start = 1'b1; mode = 3'd0; operand = 32'h1234_5678; shamt = 5'd8;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; mode = 3'd2; operand = 32'hFFFF_FFFF; shamt = 5'd3;
        @(negedge clk); start = 1'b0;
        wait_idle(c1, c4);
        check("ignored start s1", res1, 32'h0012_3456);
        check("ignored start s4", res4, 32'h0012_3456);

        // Asynchronous clear in the middle of a long shift.
        @(negedge clk);
        start = 1'b1; mode = 3'd0; operand = 32'h0000_00FF; shamt = 5'd20;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        #2 clr = 1'b1;
        #1;
        check("midop clr busy",   {30'b0, busy1, busy4}, 32'd0);
        check("midop clr done",   {30'b0, done1, done4}, 32'd0);
        check("midop clr result", res1 | res4, 32'h0);
        @(negedge clk);
        #2 clr = 1'b0;
        run_op(3'd0, 32'h0000_000A, 5'd1, c1, c4);
        check("after clr s1", res1, 32'h0000_0005);
        check("after clr s4", res4, 32'h0000_0005);

        // Random traffic: back-to-back and ignored starts, occasional clears.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            #2;
            start   = ($urandom_range(3) == 0);
            mode    = 3'($urandom);
            operand = $urandom;
            shamt   = 5'($urandom);
            clr     = ($urandom_range(399) == 0);
        end
        @(negedge clk);
        #2 clr = 1'b0; start = 1'b0;
        @(negedge clk);
        wait_idle(c1, c4);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
